sfpga_tap_frame_rx: RTL and testbench

Receive-side frame parser for the slave-FPGA serial link. Consumes the byte stream recovered from the link and decodes tap-write frames (header, command, address, length, data words, checksum). It produces the `tap_wr_cmd` / `tap_wr_addr` / `tap_wr_vld` / `tap_wr_data` strobes consumed by the downstream tap-write checker and register path. It also keeps good/bad frame counters for link diagnostics.

---
 rtl/sfpga_link_pkg.sv | 20 ++
 rtl/sfpga_rx_timeout.sv | 31 +++
 rtl/sfpga_tap_frame_rx.sv | 141 ++++++++++++++
 tb/tb_sfpga_tap_frame_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfpga_link_pkg.sv
// Shared constants and FSM state encoding for the slave-FPGA serial link.
package sfpga_link_pkg;

  localparam logic [7:0] HDR0       = 8'h5A;
  localparam logic [7:0] HDR1       = 8'hA5;
  localparam logic [7:0] CMD_WR     = 8'h01;
  localparam int         TAP_ADDR_W = 32;

  // Each state names the byte the parser expects next
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H1,
    ST_CMD,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM
  } rx_state_e;

endpackage

// File: rtl/sfpga_rx_timeout.sv
// Inter-byte gap counter: clears on every valid byte, and tc is high once the gap reaches TIMEOUT_CYC.
// tc is combinational from the count register; the count restarts when tc fires or when inactive.
module sfpga_rx_timeout #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic active,
  input  logic vld,
  output logic tc
);
  import sfpga_link_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  assign tc = active && (cnt == CW'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || vld || !active || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sfpga_tap_frame_rx.sv
// Tap-write frame parser: decodes link frames into tap strobes and keeps good/bad frame counters.
// All outputs registered, strobes one cycle after the accepting byte; no backpressure on rx_vld.
module sfpga_tap_frame_rx #(
  parameter int         TIMEOUT_CYC = 1000,
  parameter logic [7:0] HDR0        = sfpga_link_pkg::HDR0,
  parameter logic [7:0] HDR1        = sfpga_link_pkg::HDR1,
  parameter logic [7:0] CMD_WR      = sfpga_link_pkg::CMD_WR
) (
  input  logic        clk_100m,
  input  logic        rst_100m,
  input  logic        sfpga_rst,
  input  logic        cfg_clr,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        tap_wr_cmd,
  output logic [31:0] tap_wr_addr,
  output logic        tap_wr_vld,
  output logic [31:0] tap_wr_data,
  output logic [15:0] frm_ok_cnt,
  output logic [15:0] frm_err_cnt,
  output logic        frm_err
);
  import sfpga_link_pkg::*;

  rx_state_e   state, state_nxt, cur;
  logic        tc, is_wr, cmd_hit, word_hit, ok_evt, err_evt;
  logic [1:0]  byte_idx;
  logic [7:0]  words_left, sum;
  logic [23:0] shreg;

  sfpga_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk_100m),
    .rst    (rst_100m),
    .clr    (sfpga_rst),
    .active (state != ST_IDLE),
    .vld    (rx_vld),
    .tc     (tc)
  );

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A byte arriving in the timeout cycle is parsed as if the FSM were already idle
  always_comb begin
    cur       = tc ? ST_IDLE : state;
    state_nxt = cur;
    cmd_hit   = 1'b0;
    word_hit  = 1'b0;
    ok_evt    = 1'b0;
    err_evt   = tc;
    if (rx_vld) begin
      case (cur)
        ST_IDLE: if (rx_data == HDR0) state_nxt = ST_H1;
        ST_H1: begin
          if (rx_data == HDR1)      state_nxt = ST_CMD;
          else if (rx_data != HDR0) state_nxt = ST_IDLE;
        end
        ST_CMD:  state_nxt = ST_ADDR;
        ST_ADDR: begin
          if (byte_idx == 2'd3) begin
            state_nxt = ST_LEN;
            cmd_hit   = is_wr;
          end
        end
        ST_LEN:  state_nxt = (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
        ST_DATA: begin
          if (byte_idx == 2'd3) begin
            word_hit = is_wr;
            if (words_left == 8'd1) state_nxt = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_nxt = ST_IDLE;
          ok_evt    = (rx_data == sum);
          err_evt   = (rx_data != sum);
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    if (sfpga_rst) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      tap_wr_cmd  <= 1'b0;
      tap_wr_vld  <= 1'b0;
      frm_err     <= 1'b0;
      tap_wr_addr <= '0;
      tap_wr_data <= '0;
      frm_ok_cnt  <= '0;
      frm_err_cnt <= '0;
      is_wr       <= 1'b0;
      byte_idx    <= '0;
      words_left  <= '0;
      sum         <= '0;
      shreg       <= '0;
    end else begin
      tap_wr_cmd <= cmd_hit && !sfpga_rst;
      tap_wr_vld <= word_hit && !sfpga_rst;
      frm_err    <= err_evt && !sfpga_rst;
      if (cmd_hit && !sfpga_rst)  tap_wr_addr <= {shreg, rx_data};
      if (word_hit && !sfpga_rst) tap_wr_data <= {shreg, rx_data};
      if (rx_vld) begin
        shreg <= {shreg[15:0], rx_data};
        case (cur)
          ST_H1: if (rx_data == HDR1) sum <= '0;
          ST_CMD: begin
            is_wr    <= (rx_data == CMD_WR);
            sum      <= sum + rx_data;
            byte_idx <= '0;
          end
          ST_ADDR: begin
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
          end
          ST_LEN: begin
            sum        <= sum + rx_data;
            words_left <= rx_data;
            byte_idx   <= '0;
          end
          ST_DATA: begin
            sum      <= sum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) words_left <= words_left - 8'd1;
          end
          default: ;
        endcase
      end
      if (sfpga_rst || cfg_clr) begin
        frm_ok_cnt  <= '0;
        frm_err_cnt <= '0;
      end else begin
        if (ok_evt && frm_ok_cnt != 16'hFFFF)   frm_ok_cnt  <= frm_ok_cnt + 16'd1;
        if (err_evt && frm_err_cnt != 16'hFFFF) frm_err_cnt <= frm_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sfpga_tap_frame_rx.sv
// Bench for sfpga_tap_frame_rx: frames built from their field values, expectations derived from frame contents.
module tb_sfpga_tap_frame_rx;
  localparam int         TO = 20;
  localparam logic [7:0] H0 = 8'h5A;
  localparam logic [7:0] H1 = 8'hA5;
  localparam logic [7:0] CW = 8'h01;

  logic        clk_100m = 1'b0;
  logic        rst_100m, sfpga_rst, cfg_clr, rx_vld;
  logic [7:0]  rx_data;
  logic        tap_wr_cmd, tap_wr_vld, frm_err;
  logic [31:0] tap_wr_addr, tap_wr_data;
  logic [15:0] frm_ok_cnt, frm_err_cnt;

  int n_pass = 0, n_fail = 0, n_chk = 0;
  logic [31:0] obs_addr[$], obs_data[$];
  int obs_err = 0;
  logic [31:0] exp_addr[$], exp_data[$];
  int exp_ok = 0, exp_err = 0, exp_errp = 0;
  int mark_a = 0, mark_d = 0, mark_e = 0;
  logic [7:0]  fq[$];
  logic [31:0] fw[$];

  always #5 clk_100m = ~clk_100m;

  sfpga_tap_frame_rx #(.TIMEOUT_CYC(TO)) dut (
    .clk_100m   (clk_100m),
    .rst_100m   (rst_100m),
    .sfpga_rst  (sfpga_rst),
    .cfg_clr    (cfg_clr),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .tap_wr_cmd (tap_wr_cmd),
    .tap_wr_addr(tap_wr_addr),
    .tap_wr_vld (tap_wr_vld),
    .tap_wr_data(tap_wr_data),
    .frm_ok_cnt (frm_ok_cnt),
    .frm_err_cnt(frm_err_cnt),
    .frm_err    (frm_err)
  );

  always @(negedge clk_100m) begin
    if (!rst_100m) begin
      if (tap_wr_cmd) obs_addr.push_back(tap_wr_addr);
      if (tap_wr_vld) obs_data.push_back(tap_wr_data);
      if (frm_err) obs_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_100m);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    cyc(gap);
    rx_data = b;
    rx_vld  = 1'b1;
    cyc(1);
    rx_vld  = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i <= hi; i++) send_byte(fq[i], $urandom_range(0, maxgap));
  endtask

  // Frame bytes from field values; checksum is the plain byte sum from CMD through data
  task automatic make_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic bad);
    int s;
    logic [7:0] b;
    fq.delete();
    fq.push_back(H0);
    fq.push_back(H1);
    fq.push_back(cmd);
    s = int'(cmd);
    for (int k = 3; k >= 0; k--) begin
      b = addr[8*k +: 8];
      fq.push_back(b);
      s += int'(b);
    end
    fq.push_back(8'(fw.size()));
    s += fw.size();
    foreach (fw[w]) begin
      for (int k = 3; k >= 0; k--) begin
        b = fw[w][8*k +: 8];
        fq.push_back(b);
        s += int'(b);
      end
    end
    b = s[7:0] ^ {7'd0, bad};
    fq.push_back(b);
  endtask

  task automatic expect_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic bad);
    if (cmd == CW) begin
      exp_addr.push_back(addr);
      foreach (fw[w]) exp_data.push_back(fw[w]);
    end
    if (bad) begin
      exp_err++;
      exp_errp++;
    end else begin
      exp_ok++;
    end
  endtask

  task automatic clr_cnt();
    cfg_clr = 1'b1;
    cyc(1);
    cfg_clr = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
  endtask

  task automatic check_step(input string tag);
    cyc(3);
    check({tag, " cmd_n"}, 32'(obs_addr.size() - mark_a), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && mark_a + i < obs_addr.size(); i++)
      check({tag, " addr"}, obs_addr[mark_a+i], exp_addr[i]);
    check({tag, " vld_n"}, 32'(obs_data.size() - mark_d), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && mark_d + i < obs_data.size(); i++)
      check({tag, " data"}, obs_data[mark_d+i], exp_data[i]);
    check({tag, " err_pulses"}, 32'(obs_err - mark_e), 32'(exp_errp));
    check({tag, " ok_cnt"}, {16'd0, frm_ok_cnt}, 32'(exp_ok));
    check({tag, " err_cnt"}, {16'd0, frm_err_cnt}, 32'(exp_err));
    mark_a = obs_addr.size();
    mark_d = obs_data.size();
    mark_e = obs_err;
    exp_addr.delete();
    exp_data.delete();
    exp_errp = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " cmd"}, {31'd0, tap_wr_cmd}, 32'd0);
    check({tag, " vld"}, {31'd0, tap_wr_vld}, 32'd0);
    check({tag, " frm_err"}, {31'd0, frm_err}, 32'd0);
    check({tag, " addr"}, tap_wr_addr, 32'd0);
    check({tag, " data"}, tap_wr_data, 32'd0);
    check({tag, " ok_cnt"}, {16'd0, frm_ok_cnt}, 32'd0);
    check({tag, " err_cnt"}, {16'd0, frm_err_cnt}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  c, j;
    logic        bad;
    rst_100m  = 1'b1;
    sfpga_rst = 1'b0;
    cfg_clr   = 1'b0;
    rx_vld    = 1'b0;
    rx_data   = 8'h00;
    cyc(3);
    rst_100m = 1'b0;
    cyc(1);
    check_outputs_zero("reset");

    // Directed write frame with good checksum
    clr_cnt();
    fw = '{32'h11223344, 32'hAABBCCDD};
    make_frame(CW, 32'h0004_0004, 1'b0);
    send_range(0, fq.size() - 1, 0);
    expect_frame(CW, 32'h0004_0004, 1'b0);
    check_step("wr_ok");

    // Same frame, checksum corrupted: strobes still issued
    clr_cnt();
    make_frame(CW, 32'h0004_0004, 1'b1);
    send_range(0, fq.size() - 1, 1);
    expect_frame(CW, 32'h0004_0004, 1'b1);
    check_step("wr_badsum");

    // Repeated HDR0 before HDR1, zero-length frame
    clr_cnt();
    fw.delete();
    a = $urandom;
    make_frame(CW, a, 1'b0);
    fq.push_front(H0);
    send_range(0, fq.size() - 1, 0);
    expect_frame(CW, a, 1'b0);
    check_step("resync_len0");

    // Stall after two data bytes, then a fresh frame
    clr_cnt();
    fw = '{$urandom, $urandom};
    a = $urandom;
    make_frame(CW, a, 1'b0);
    send_range(0, 9, 0);
    cyc(TO + 10);
    exp_addr.push_back(a);
    exp_err++;
    exp_errp++;
    fw = '{$urandom};
    a = $urandom;
    make_frame(CW, a, 1'b0);
    send_range(0, fq.size() - 1, 2);
    expect_frame(CW, a, 1'b0);
    check_step("timeout");

    // Non-write command: parsed and checksummed only
    clr_cnt();
    fw = '{$urandom};
    make_frame(8'h02, $urandom, 1'b0);
    send_range(0, fq.size() - 1, 0);
    expect_frame(8'h02, 32'd0, 1'b0);
    check_step("cmd02");

    // Soft reset mid-address: no strobes, counters cleared
    fw = '{$urandom, $urandom};
    make_frame(CW, $urandom, 1'b0);
    send_range(0, 4, 0);
    sfpga_rst = 1'b1;
    cyc(1);
    sfpga_rst = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    check_step("srst");

    // Hard reset mid-data, then a full frame
    a = $urandom;
    make_frame(CW, a, 1'b0);
    send_range(0, 10, 0);
    exp_addr.push_back(a);
    rst_100m = 1'b1;
    cyc(1);
    rst_100m = 1'b0;
    check_outputs_zero("hard_rst");
    fw = '{$urandom};
    a = $urandom;
    make_frame(CW, a, 1'b0);
    send_range(0, fq.size() - 1, 1);
    expect_frame(CW, a, 1'b0);
    check_step("after_rst");

    // Random frames with junk between them and random inter-byte gaps
    for (int f = 0; f < 25; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        j = 8'($urandom);
        if (j == H0) j = 8'h00;
        send_byte(j, $urandom_range(0, 2));
      end
      fw.delete();
      for (int w = $urandom_range(0, 5); w > 0; w--) fw.push_back($urandom);
      c   = ($urandom_range(0, 3) == 0) ? 8'h02 : CW;
      a   = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      make_frame(c, a, bad);
      send_range(0, fq.size() - 1, 3);
      expect_frame(c, a, bad);
      if (f % 5 == 4) check_step("random");
    end
    check_step("random_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
